bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter that uses the shift-add-3 (double-dabble) method, one input bit per clock.
- Sits directly upstream of the four-digit seven-segment decoder and feeds it packed BCD digits.
- Replaces wide divide/modulo logic with a small iterative datapath.
- Holds the last result stable while a new conversion runs, so the display never flickers.

---
 rtl/display_pkg.sv | 13 +
 rtl/bcd_digit_adj3.sv | 11 +
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 tb/tb_bin2bcd_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the display datapath
package display_pkg;

    localparam int BCD_W          = 4;
    localparam int DIGITS_DEFAULT = 4;
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_digit_adj3.sv
// rtl/bcd_digit_adj3.sv - double-dabble digit correction: add 3 when digit >= 5
module bcd_digit_adj3
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    assign q = (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter, one input bit per clock
// Optional leading-zero blanking: define BIN2BCD_LEADING_BLANK_EN.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = DIGITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       value,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int BW = BCD_W * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(IN_WIDTH - 1);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_CONV = CONV;

    logic [0:0]          state;
    logic [IN_WIDTH-1:0] shreg;
    logic [BW-1:0]       work;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       nxt_work;
    logic [BW-1:0]       result;
    logic                ovf_sticky;
    logic                nxt_ovf;
    logic [CW-1:0]       cnt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .d (work[BCD_W*i +: BCD_W]),
            .q (adj[BCD_W*i +: BCD_W])
        );
    end

    // Anything shifted out of the top digit means the value did not fit.
    assign nxt_work = {adj[BW-2:0], shreg[IN_WIDTH-1]};
    assign nxt_ovf  = ovf_sticky | adj[BW-1];

`ifdef BIN2BCD_LEADING_BLANK_EN
    logic leading;

    always_comb begin
        result  = nxt_work;
        leading = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (nxt_work[BCD_W*i +: BCD_W] == '0)) begin
                result[BCD_W*i +: BCD_W] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign result = nxt_work;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            work       <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg      <= value;
                        work       <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= S_CONV;
                    end
                end
                S_CONV: begin
                    shreg      <= {shreg[IN_WIDTH-2:0], 1'b0};
                    work       <= nxt_work;
                    ovf_sticky <= nxt_ovf;
                    cnt        <= cnt + CW'(1);
                    // Publish on the final shift so the display updates exactly once.
                    if (cnt == LAST_CNT) begin
                        bcd      <= result;
                        overflow <= nxt_ovf;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_WIDTH(32), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    typedef struct {
        logic [31:0] v;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: decimal digits of value mod 10^4 via plain arithmetic.
    function automatic logic [16:0] model(input logic [31:0] v);
        longint unsigned m;
        logic [15:0] b;
        logic lead;
        m = longint'(v) % 10000;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BIN2BCD_LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && b[4*i +: 4] == 4'h0) b[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return {(v >= 32'd10000) | (lead & 1'b0), b};
    endfunction

    task automatic run(input logic [31:0] v, output logic ok, output int busy_n,
                       output logic stable, output logic [15:0] b, output logic o);
        logic [15:0] b0;
        @(negedge clk);
        b0 = bcd;
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
        ok = 1'b0;
        busy_n = 0;
        stable = 1'b1;
        b = '0;
        o = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                b = bcd;
                o = overflow;
                break;
            end
            if (busy) busy_n++;
            if (bcd !== b0) stable = 1'b0;
        end
    endtask

    vec_t vecs[7];
    logic ok, stable, o;
    logic [15:0] b;
    int busy_n;
    logic [16:0] e;

    initial begin
`ifdef BIN2BCD_LEADING_BLANK_EN
        vecs[0] = '{32'd1234,       16'h1234, 1'b0};
        vecs[1] = '{32'd0,          16'hFFF0, 1'b0};
        vecs[2] = '{32'd42,         16'hFF42, 1'b0};
        vecs[3] = '{32'd9999,       16'h9999, 1'b0};
        vecs[4] = '{32'd10000,      16'hFFF0, 1'b1};
        vecs[5] = '{32'hFFFFFFFF,   16'h7295, 1'b1};
        vecs[6] = '{32'd100,        16'hF100, 1'b0};
`else
        vecs[0] = '{32'd1234,       16'h1234, 1'b0};
        vecs[1] = '{32'd0,          16'h0000, 1'b0};
        vecs[2] = '{32'd42,         16'h0042, 1'b0};
        vecs[3] = '{32'd9999,       16'h9999, 1'b0};
        vecs[4] = '{32'd10000,      16'h0000, 1'b1};
        vecs[5] = '{32'hFFFFFFFF,   16'h7295, 1'b1};
        vecs[6] = '{32'd100,        16'h0100, 1'b0};
`endif

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            run(vecs[t].v, ok, busy_n, stable, b, o);
            chk($sformatf("vec%0d_done", t), 32'(ok), 32'd1);
            chk($sformatf("vec%0d_bcd", t), 32'(b), 32'(vecs[t].exp_bcd));
            chk($sformatf("vec%0d_ovf", t), 32'(o), 32'(vecs[t].exp_ovf));
            chk($sformatf("vec%0d_busy_cycles", t), 32'(busy_n), 32'd32);
            chk($sformatf("vec%0d_hold", t), 32'(stable), 32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", t), 32'(done), 32'd0);
        end

        begin : ignore_start
            int dones;
            logic [15:0] got;
            dones = 0;
            got = '0;
            @(negedge clk);
            start = 1'b1;
            value = 32'd55;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (10) @(negedge clk);
            start = 1'b1;
            value = 32'd77;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 70; i++) begin
                @(negedge clk);
                if (done) begin
                    dones++;
                    got = bcd;
                end
            end
            e = model(32'd55);
            chk("ignore_done_count", 32'(dones), 32'd1);
            chk("ignore_bcd", 32'(got), 32'(e[15:0]));
        end

        begin : mid_reset
            int dones;
            dones = 0;
            @(negedge clk);
            start = 1'b1;
            value = 32'd9999;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (16) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_bcd", 32'(bcd), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk("rst_no_done", 32'(dones), 32'd0);
            run(32'd42, ok, busy_n, stable, b, o);
            e = model(32'd42);
            chk("rst_after_done", 32'(ok), 32'd1);
            chk("rst_after_bcd", 32'(b), 32'(e[15:0]));
        end

        begin : held_start
            int idx[2];
            logic [15:0] got[2];
            int n;
            logic hold_ok;
            n = 0;
            hold_ok = 1'b1;
            idx[0] = 0; idx[1] = 0;
            got[0] = '0; got[1] = '0;
            @(negedge clk);
            start = 1'b1;
            value = 32'd123;
            @(posedge clk);
            #1 value = 32'd456;
            for (int i = 0; i < 100 && n < 2; i++) begin
                @(negedge clk);
                if (done) begin
                    idx[n] = i;
                    got[n] = bcd;
                    n++;
                end else if (n == 1 && bcd !== got[0]) begin
                    hold_ok = 1'b0;
                end
            end
            start = 1'b0;
            chk("held_two_dones", 32'(n), 32'd2);
            chk("held_period", 32'(idx[1] - idx[0]), 32'd33);
            e = model(32'd123);
            chk("held_bcd0", 32'(got[0]), 32'(e[15:0]));
            e = model(32'd456);
            chk("held_bcd1", 32'(got[1]), 32'(e[15:0]));
            chk("held_stable", 32'(hold_ok), 32'd1);
            repeat (40) @(negedge clk);
        end

        for (int t = 0; t < 30; t++) begin
            logic [31:0] v;
            case (t % 3)
                0: v = $urandom_range(0, 9999);
                1: v = $urandom_range(9990, 20000);
                default: v = $urandom;
            endcase
            run(v, ok, busy_n, stable, b, o);
            e = model(v);
            chk($sformatf("rnd%0d_done", t), 32'(ok), 32'd1);
            chk($sformatf("rnd%0d_bcd v=%0d", t, v), 32'(b), 32'(e[15:0]));
            chk($sformatf("rnd%0d_ovf v=%0d", t, v), 32'(o), 32'(e[16]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
